// File: rtl/delay_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : delay_addr_gen
// Purpose  : Address/strobe generator that turns a dual-port RAM into a
//            programmable sample delay line.
// Revision : 1.0 - initial release
// ============================================================================
module delay_addr_gen #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [DATA_WIDTH-1:0]    sample_in,
  input  logic [ADDRESS_WIDTH-1:0] offset,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]    din,
  output logic                     rd_en,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic                     dout_valid,
  output logic                     primed
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_fill = 2'd1;
  localparam logic [1:0] c_run  = 2'd2;

  localparam logic [ADDRESS_WIDTH-1:0] c_one      = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDRESS_WIDTH-1:0] c_fcnt_max = {ADDRESS_WIDTH{1'b1}};

  logic [1:0]               r_rst_sync;
  logic [1:0]               r_state;
  logic [1:0]               w_next_state;
  logic [ADDRESS_WIDTH-1:0] r_wptr;
  logic [ADDRESS_WIDTH-1:0] r_fcnt;
  logic [ADDRESS_WIDTH-1:0] w_eoff;
  logic                     w_accept;
  logic                     w_have_history;
  logic                     w_rd_issue;
  logic                     w_primed_next;

  // Reset asserts asynchronously but the release is re-timed to clk, so
  // samples are only accepted once the synchroniser has filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_accept       = en & r_rst_sync[1];
  assign w_eoff         = (offset == '0) ? c_one : offset;
  assign w_have_history = (r_fcnt >= w_eoff);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; transitions are only evaluated on accepted samples so
  // an offset change is seen on the next en.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle: if (w_accept)                   w_next_state = c_fill;
      c_fill: if (w_accept && w_have_history) w_next_state = c_run;
      c_run:  if (w_accept && !w_have_history) w_next_state = c_fill;
      default:                                w_next_state = c_idle;
    endcase
  end

  // Output decode
  always_comb begin
    w_rd_issue    = 1'b0;
    w_primed_next = 1'b0;
    if (w_accept && (r_state != c_idle) && w_have_history) begin
      w_rd_issue = 1'b1;
    end
    if (w_next_state == c_run) begin
      w_primed_next = 1'b1;
    end
  end

  // Datapath: pointers, fill count and registered RAM strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_fcnt     <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      din        <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      dout_valid <= 1'b0;
      primed     <= 1'b0;
    end else begin
      wr_en      <= w_accept;
      rd_en      <= w_rd_issue;
      dout_valid <= rd_en;
      primed     <= w_primed_next;
      if (w_accept) begin
        wr_addr <= r_wptr;
        din     <= sample_in;
        r_wptr  <= r_wptr + c_one;
        if (r_fcnt != c_fcnt_max) begin
          r_fcnt <= r_fcnt + c_one;
        end
      end
      // eoff >= 1 keeps the read address strictly behind the write address
      if (w_rd_issue) begin
        rd_addr <= r_wptr - w_eoff;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_delay_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_addr_gen
// Purpose  : Directed self-checking bench for delay_addr_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_delay_addr_gen;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] sample_in;
  logic [8:0] offset;
  logic       wr_en;
  logic [8:0] wr_addr;
  logic [7:0] din;
  logic       rd_en;
  logic [8:0] rd_addr;
  logic       dout_valid;
  logic       primed;

  int checks   = 0;
  int failures = 0;

  delay_addr_gen #(.ADDRESS_WIDTH(9), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sample_in  (sample_in),
    .offset     (offset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .din        (din),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .dout_valid (dout_valid),
    .primed     (primed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic e, input logic [7:0] s);
    @(negedge clk);
    en        = e;
    sample_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"},      32'(wr_en),      0);
    check({tag, "_wr_addr"},    32'(wr_addr),    0);
    check({tag, "_din"},        32'(din),        0);
    check({tag, "_rd_en"},      32'(rd_en),      0);
    check({tag, "_rd_addr"},    32'(rd_addr),    0);
    check({tag, "_dout_valid"}, 32'(dout_valid), 0);
    check({tag, "_primed"},     32'(primed),     0);
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    sample_in = 8'd0;
    offset    = 9'd3;

    // Power-on reset
    #7;
    check_all_zero("por");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Priming with offset 3: samples 10,20,30,40 as isolated pulses
    tick(1'b1, 8'd10);
    check("p1_wr_en", 32'(wr_en), 1);
    check("p1_wr_addr", 32'(wr_addr), 0);
    check("p1_din", 32'(din), 10);
    check("p1_rd_en", 32'(rd_en), 0);
    tick(1'b0, 8'd0);
    check("p1_wr_en_pulse", 32'(wr_en), 0);
    check("p1_wr_addr_hold", 32'(wr_addr), 0);
    tick(1'b1, 8'd20);
    check("p2_rd_en", 32'(rd_en), 0);
    check("p2_wr_addr", 32'(wr_addr), 1);
    tick(1'b0, 8'd0);
    tick(1'b1, 8'd30);
    check("p3_rd_en", 32'(rd_en), 0);
    check("p3_primed", 32'(primed), 0);
    tick(1'b0, 8'd0);
    tick(1'b1, 8'd40);
    check("p4_wr_addr", 32'(wr_addr), 3);
    check("p4_din", 32'(din), 40);
    check("p4_rd_en", 32'(rd_en), 1);
    check("p4_rd_addr", 32'(rd_addr), 0);
    check("p4_primed", 32'(primed), 1);
    check("p4_dv_early", 32'(dout_valid), 0);
    tick(1'b0, 8'd0);
    check("p4_dout_valid", 32'(dout_valid), 1);
    check("p4_rd_en_pulse", 32'(rd_en), 0);
    check("p4_din_hold", 32'(din), 40);
    tick(1'b0, 8'd0);
    check("p4_dv_pulse", 32'(dout_valid), 0);

    // Fifth write at offset 3, then increase offset to 10
    tick(1'b1, 8'd50);
    check("o5_wr_addr", 32'(wr_addr), 4);
    check("o5_rd_addr", 32'(rd_addr), 1);
    check("o5_rd_en", 32'(rd_en), 1);
    offset = 9'd10;
    tick(1'b0, 8'd0);
    check("oinc_primed_until_en", 32'(primed), 1);
    for (int j = 0; j < 5; j++) begin
      tick(1'b1, 8'(60 + j));
      check("oinc_wr_addr", 32'(wr_addr), 32'(5 + j));
      check("oinc_rd_en", 32'(rd_en), 0);
      check("oinc_primed", 32'(primed), 0);
    end
    check("oinc_rd_addr_hold", 32'(rd_addr), 1);
    tick(1'b1, 8'd99);
    check("oinc_full_wr_addr", 32'(wr_addr), 10);
    check("oinc_full_rd_en", 32'(rd_en), 1);
    check("oinc_full_rd_addr", 32'(rd_addr), 0);
    check("oinc_full_primed", 32'(primed), 1);

    // Asynchronous reset asserted between clock edges
    tick(1'b0, 8'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // History discarded; then offset 0 behaves as offset 1
    offset = 9'd3;
    tick(1'b1, 8'hA1);
    check("rr_wr_addr", 32'(wr_addr), 0);
    check("rr_din", 32'(din), 32'h A1);
    check("rr_rd_en", 32'(rd_en), 0);
    tick(1'b1, 8'hA2);
    check("rr2_wr_addr", 32'(wr_addr), 1);
    check("rr2_rd_en", 32'(rd_en), 0);
    offset = 9'd0;
    tick(1'b1, 8'hA3);
    check("off0_wr_addr", 32'(wr_addr), 2);
    check("off0_rd_en", 32'(rd_en), 1);
    check("off0_rd_addr", 32'(rd_addr), 1);
    check("off0_primed", 32'(primed), 1);
    tick(1'b0, 8'd0);

    // Continuous en for 8 cycles at offset 3
    do_reset();
    offset = 9'd3;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 8'(i + 100));
      check("cont_wr_en", 32'(wr_en), 1);
      check("cont_wr_addr", 32'(wr_addr), 32'(i));
      check("cont_din", 32'(din), 32'(i + 100));
      check("cont_rd_en", 32'(rd_en), (i >= 3) ? 1 : 0);
      check("cont_dout_valid", 32'(dout_valid), (i >= 4) ? 1 : 0);
      if (i >= 3) check("cont_rd_addr", 32'(rd_addr), 32'(i - 3));
    end
    tick(1'b0, 8'd0);
    check("cont_end_wr_en", 32'(wr_en), 0);
    check("cont_end_rd_en", 32'(rd_en), 0);
    check("cont_end_dv", 32'(dout_valid), 1);
    check("cont_end_wr_addr", 32'(wr_addr), 7);
    check("cont_end_rd_addr", 32'(rd_addr), 4);

    // Address wrap with 514 back-to-back samples at offset 3
    do_reset();
    offset = 9'd3;
    for (int k = 0; k < 514; k++) begin
      tick(1'b1, k[7:0]);
      if (k == 512) begin
        check("wrap_wr_addr", 32'(wr_addr), 0);
        check("wrap_rd_addr", 32'(rd_addr), 509);
        check("wrap_rd_en", 32'(rd_en), 1);
      end
      if (k == 513) begin
        check("wrap2_wr_addr", 32'(wr_addr), 1);
        check("wrap2_rd_addr", 32'(rd_addr), 510);
        check("wrap2_primed", 32'(primed), 1);
      end
    end
    tick(1'b0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
